// File: rtl/pilot_insert.sv
// pilot_insert: captures the OPG pilot-polarity sequence once after reset, then
// assembles 64-bin OFDM symbols (48 data, 4 polarity-scaled pilots, 12 nulls)
// in IFFT input order on a valid/ready output stream.
module pilot_insert #(
  parameter int                   DW           = 16,
  parameter logic signed [DW-1:0] PILOT_AMP    = 16'sd8192,
  parameter int                   POL_LEN      = 127,
  parameter int                   POL_START    = 0,
  parameter int                   LOAD_TIMEOUT = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 pol_rd_en,
  input  logic                 pol_di,
  input  logic                 pol_di_vld,
  output logic                 load_done,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic signed [DW-1:0] dout_i,
  output logic signed [DW-1:0] dout_q,
  output logic [5:0]           dout_idx,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 dout_sof,
  output logic                 dout_eof
);

  localparam int BCW = $clog2(POL_LEN + 1);
  localparam int PIW = (POL_LEN > 1) ? $clog2(POL_LEN) : 1;
  localparam int TOW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic signed [DW-1:0] AMP_POS = PILOT_AMP;
  localparam logic signed [DW-1:0] AMP_NEG = -PILOT_AMP;

  // Per-bin role tables: data bins, pilot bins, and pilots whose base sign is -1.
  logic [63:0] data_map;
  logic [63:0] pilot_map;
  logic [63:0] pneg_map;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_bin_map
      localparam bit IS_NULL  = (gi == 0) || ((gi >= 27) && (gi <= 37));
      localparam bit IS_PILOT = (gi == 7) || (gi == 21) || (gi == 43) || (gi == 57);
      localparam bit IS_PNEG  = (gi == 21);
      assign data_map[gi]  = !IS_NULL && !IS_PILOT;
      assign pilot_map[gi] = IS_PILOT;
      assign pneg_map[gi]  = IS_PNEG;
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TOW-1:0]     to_cnt_q, to_cnt_d;
  logic [POL_LEN-1:0] pol_reg_q, pol_reg_d;
  logic               pol_rd_en_q, pol_rd_en_d;
  logic               load_done_q, load_done_d;

  logic [5:0]         bin_q, bin_d;
  logic [PIW-1:0]     pol_idx_q, pol_idx_d;
  logic signed [DW-1:0] dout_i_q, dout_i_d;
  logic signed [DW-1:0] dout_q_q, dout_q_d;
  logic [5:0]         dout_idx_q, dout_idx_d;
  logic               dout_vld_q, dout_vld_d;
  logic               dout_sof_q, dout_sof_d;
  logic               dout_eof_q, dout_eof_d;

  logic run;
  logic out_free;
  logic cur_data;
  logic advance;
  logic pilot_neg;

  // Load FSM: issue a one-cycle request, collect POL_LEN bits, retry on timeout.
  // The timeout counter holds "cycles since the last accepted bit", so the
  // accepting cycle loads 1 and a retry request lands LOAD_TIMEOUT cycles later.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    pol_reg_d   = pol_reg_q;
    pol_rd_en_d = 1'b0;
    load_done_d = load_done_q;
    case (state_q)
      S_REQ: begin
        if (pol_rd_en_q) begin
          state_d = S_WAIT;
        end else begin
          pol_rd_en_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (pol_di_vld) begin
          pol_reg_d[bit_cnt_q] = pol_di;
          bit_cnt_d            = bit_cnt_q + BCW'(1);
          to_cnt_d             = TOW'(1);
          if (bit_cnt_d == BCW'(POL_LEN)) begin
            state_d     = S_RUN;
            load_done_d = 1'b1;
          end
        end else if (to_cnt_q == TOW'(LOAD_TIMEOUT - 1)) begin
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          state_d     = S_REQ;
          pol_rd_en_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      default: ;
    endcase
  end

  // Symbol builder: one bin per advance; data bins wait for din, others never do.
  always_comb begin
    run       = (state_q == S_RUN);
    out_free  = !dout_vld_q || dout_rdy;
    cur_data  = data_map[bin_q];
    din_rdy   = run && cur_data && out_free;
    advance   = run && out_free && (cur_data ? din_vld : 1'b1);
    pilot_neg = pneg_map[bin_q] ^ pol_reg_q[pol_idx_q];

    bin_d      = bin_q;
    pol_idx_d  = pol_idx_q;
    dout_i_d   = dout_i_q;
    dout_q_d   = dout_q_q;
    dout_idx_d = dout_idx_q;
    dout_vld_d = dout_vld_q;
    dout_sof_d = dout_sof_q;
    dout_eof_d = dout_eof_q;

    if (advance) begin
      if (cur_data) begin
        dout_i_d = din_i;
        dout_q_d = din_q;
      end else if (pilot_map[bin_q]) begin
        dout_i_d = pilot_neg ? AMP_NEG : AMP_POS;
        dout_q_d = '0;
      end else begin
        dout_i_d = '0;
        dout_q_d = '0;
      end
      dout_idx_d = bin_q;
      dout_vld_d = 1'b1;
      dout_sof_d = (bin_q == 6'd0);
      dout_eof_d = (bin_q == 6'd63);
      bin_d      = bin_q + 6'd1;
      if (bin_q == 6'd63) begin
        pol_idx_d = (pol_idx_q == PIW'(POL_LEN - 1)) ? '0 : pol_idx_q + PIW'(1);
      end
    end else if (dout_rdy) begin
      dout_vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pol_reg_q   <= '0;
      pol_rd_en_q <= 1'b0;
      load_done_q <= 1'b0;
      bin_q       <= '0;
      pol_idx_q   <= PIW'(POL_START);
      dout_i_q    <= '0;
      dout_q_q    <= '0;
      dout_idx_q  <= '0;
      dout_vld_q  <= 1'b0;
      dout_sof_q  <= 1'b0;
      dout_eof_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pol_reg_q   <= pol_reg_d;
      pol_rd_en_q <= pol_rd_en_d;
      load_done_q <= load_done_d;
      bin_q       <= bin_d;
      pol_idx_q   <= pol_idx_d;
      dout_i_q    <= dout_i_d;
      dout_q_q    <= dout_q_d;
      dout_idx_q  <= dout_idx_d;
      dout_vld_q  <= dout_vld_d;
      dout_sof_q  <= dout_sof_d;
      dout_eof_q  <= dout_eof_d;
    end
  end

  assign pol_rd_en = pol_rd_en_q;
  assign load_done = load_done_q;
  assign dout_i    = dout_i_q;
  assign dout_q    = dout_q_q;
  assign dout_idx  = dout_idx_q;
  assign dout_vld  = dout_vld_q;
  assign dout_sof  = dout_sof_q;
  assign dout_eof  = dout_eof_q;

endmodule

// File: tb/tb_pilot_insert.sv
// tb_pilot_insert: scoreboard bench for pilot_insert with an OPG reply model.
module tb_pilot_insert;

  localparam int POL_LEN = 127;
  localparam int TMO     = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pol_rd_en;
  logic        pol_di = 1'b0;
  logic        pol_di_vld = 1'b0;
  logic        load_done;
  logic [15:0] din_i = '0;
  logic [15:0] din_q = '0;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [15:0] dout_i;
  logic [15:0] dout_q;
  logic [5:0]  dout_idx;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic        dout_sof;
  logic        dout_eof;

  pilot_insert dut (
    .clk(clk), .rst(rst),
    .pol_rd_en(pol_rd_en), .pol_di(pol_di), .pol_di_vld(pol_di_vld), .load_done(load_done),
    .din_i(din_i), .din_q(din_q), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout_i(dout_i), .dout_q(dout_q), .dout_idx(dout_idx), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .dout_sof(dout_sof), .dout_eof(dout_eof)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          pol_bits [POL_LEN];
  logic [31:0] dq [$];
  int          m_bin = 0, m_pol = 0, m_sym = 0, m_dcnt = 0;
  bit          hold_pending = 0;
  logic [63:0] hold_snap = '0;
  bit          count_bubbles = 0, seen_sof = 0, t2_phase = 0, rand_mode = 0, din_taken = 0;
  int          bubbles = 0;
  int          rd_cnt = 0;
  logic [15:0] data_ctr = 16'd1;

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sym %0d bin %0d)", tag, got, exp, m_sym, m_bin);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_pol = 0; m_sym = 0; m_dcnt = 0;
    dq.delete();
    hold_pending = 0;
    seen_sof = 0;
  endtask

  // Score one output transfer against the bench's own symbol model.
  task automatic score_beat();
    logic [15:0] exp_i, exp_q, ref_i;
    logic [31:0] w;
    bit is_null, is_pilot;
    int base, p;
    is_null  = (m_bin == 0) || (m_bin >= 27 && m_bin <= 37);
    is_pilot = (m_bin == 7) || (m_bin == 21) || (m_bin == 43) || (m_bin == 57);
    exp_i = '0;
    exp_q = '0;
    tb_check("idx", 64'(dout_idx), 64'(m_bin));
    tb_check("sof_eof", 64'({dout_sof, dout_eof}), 64'({m_bin == 0, m_bin == 63}));
    if (is_pilot) begin
      base  = (m_bin == 21) ? -1 : 1;
      p     = pol_bits[m_pol] ? -1 : 1;
      exp_i = 16'(base * p * 8192);
      if (m_sym == 0 || m_sym == 4 || m_sym == 127) begin
        ref_i = ((m_sym == 4) != (m_bin == 21)) ? 16'hE000 : 16'h2000;
        tb_check("pilot_ref", 64'(dout_i), 64'(ref_i));
      end
    end else if (!is_null) begin
      if (dq.size() == 0) begin
        tb_check("din_available", 64'(0), 64'(1));
        exp_i = dout_i;
        exp_q = dout_q;
      end else begin
        w     = dq.pop_front();
        exp_i = w[31:16];
        exp_q = w[15:0];
      end
      if (t2_phase && m_sym == 0) tb_check("sym0_data", 64'(dout_i), 64'(m_dcnt + 1));
      m_dcnt++;
    end
    tb_check("dout_i", 64'(dout_i), 64'(exp_i));
    tb_check("dout_q", 64'(dout_q), 64'(exp_q));
    if (m_bin == 0) seen_sof = 1;
    if (m_bin == 63) begin
      $display("symbol %0d done: pol_idx %0d, data %0d", m_sym, m_pol, m_dcnt);
      m_sym++;
      m_pol  = (m_pol == POL_LEN - 1) ? 0 : m_pol + 1;
      m_bin  = 0;
      m_dcnt = 0;
    end else begin
      m_bin++;
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    logic [63:0] snap;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pol_rd_en) rd_cnt++;
        if (din_vld && din_rdy) begin
          dq.push_back({din_i, din_q});
          din_taken = 1;
        end
        snap = {23'd0, dout_vld, dout_i, dout_q, dout_idx, dout_sof, dout_eof};
        if (hold_pending) tb_check("hold_stable", snap, hold_snap);
        hold_pending = dout_vld && !dout_rdy;
        hold_snap    = snap;
        if (count_bubbles && seen_sof && !dout_vld) bubbles++;
        if (dout_vld && dout_rdy) score_beat();
      end
    end
  end

  // Data source and downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (din_taken) begin
        data_ctr  = data_ctr + 16'd1;
        din_taken = 0;
      end
      din_i    = data_ctr;
      din_q    = data_ctr ^ 16'hA5A5;
      din_vld  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic opg_wait_rd();
    bit seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (pol_rd_en) seen = 1;
    end
    tb_check("rd_en_seen", 64'(seen), 64'(1));
  endtask

  // OPG reply: n bits, one per cycle, starting the cycle after the request.
  task automatic opg_send(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pol_di     = pol_bits[i];
      pol_di_vld = 1'b1;
      if (n == POL_LEN && i == n - 1) tb_check("load_done_before", 64'(load_done), 64'(0));
    end
    @(posedge clk);
    #1;
    pol_di_vld = 1'b0;
    pol_di     = 1'b0;
    tb_check("load_done_after", 64'(load_done), 64'(n == POL_LEN));
  endtask

  task automatic wait_sym(input int n, input int budget);
    int k = 0;
    while (m_sym < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    tb_check("sym_reached", 64'(m_sym >= n), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no finish expected finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s;
    int k, rd_before;
    bit hit;
    s = 7'h7F;
    for (int i = 0; i < POL_LEN; i++) begin
      pol_bits[i] = s[6] ^ s[3];
      s = {s[5:0], pol_bits[i]};
    end

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    tb_check("rst_ctrl", 64'({dout_vld, dout_sof, dout_eof, load_done, pol_rd_en, din_rdy, dout_idx}), 64'(0));
    tb_check("rst_data", 64'({dout_i, dout_q}), 64'(0));

    // T1 load, then T2/T3 full-rate symbols
    t2_phase = 1;
    count_bubbles = 1;
    rst = 1'b0;
    opg_wait_rd();
    opg_send(POL_LEN);
    repeat (5) @(posedge clk);
    #1;
    tb_check("rd_pulses", 64'(rd_cnt), 64'(1));
    wait_sym(130, 9000);
    count_bubbles = 0;
    t2_phase = 0;
    tb_check("bubbles", 64'(bubbles), 64'(0));

    // T4 random backpressure and input gaps
    rand_mode = 1;
    wait_sym(140, 12000);
    rand_mode = 0;

    // T5 short reply, timeout, retry
    do_reset();
    opg_wait_rd();
    opg_send(100);
    k = 1;
    while (!pol_rd_en && k < TMO + 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    tb_check("timeout_gap", 64'(k), 64'(TMO));
    opg_send(POL_LEN);

    // T6 reset at bin 30 of symbol 2
    hit = 0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (dout_vld && dout_idx == 6'd30 && m_sym == 2) hit = 1;
    end
    tb_check("bin30_sym2_seen", 64'(hit), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    tb_check("midrst_ctrl", 64'({dout_vld, dout_sof, dout_eof, load_done, pol_rd_en, din_rdy, dout_idx}), 64'(0));
    tb_check("midrst_data", 64'({dout_i, dout_q}), 64'(0));
    rd_before = rd_cnt;
    rst = 1'b0;
    opg_wait_rd();
    opg_send(POL_LEN);
    wait_sym(2, 1000);
    tb_check("reload_rd_pulses", 64'(rd_cnt), 64'(rd_before + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
